// File: rtl/imem_dmem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package imem_dmem_arb_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int MAX_DWIN_DEF = 4;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/arb_prio.sv
// Data-first winner select with a starvation counter that forces fetch to win
// after MAX_DWIN consecutive data grants while fetch is waiting.
module arb_prio
  import imem_dmem_arb_pkg::*;
#(
  parameter int MAX_DWIN = MAX_DWIN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_fire,
  output logic sel_i,
  output logic sel_d
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] DWIN_LIM = CNT_W'(MAX_DWIN);

  logic [CNT_W-1:0] dcount;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == DWIN_LIM) ? v : v + 1'b1;
  endfunction

  always_comb begin
    sel_d = arb_en && d_req && !(i_req && (dcount == DWIN_LIM));
    sel_i = arb_en && i_req && !sel_d;
  end

  // Only data grants that actually delay a waiting fetch count toward the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcount <= '0;
    end else if (grant_fire && sel_d && i_req) begin
      dcount <= sat_inc(dcount);
    end else if ((grant_fire && sel_i) || (arb_en && !i_req)) begin
      dcount <= '0;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port memory, one
// transaction at a time, and routes the response back to the owner.
module imem_dmem_arbiter
  import imem_dmem_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_DWIN = MAX_DWIN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [DATA_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  state_t state_q, state_d;
  owner_t owner_q;
  logic   kill_q;
  logic   arb_en, sel_i, sel_d, grant_fire, ack_fire, i_deliver;

  // Gating with reset keeps grants low while the block is held in reset.
  assign arb_en     = (state_q == IDLE) && reset;
  assign grant_fire = sel_i || sel_d;
  assign ack_fire   = (state_q == ACCESS) && mem_ack;
  assign i_deliver  = ack_fire && (owner_q == OWN_I) && !kill_q && !i_flush;

  arb_prio #(.MAX_DWIN(MAX_DWIN)) u_prio (
    .clk        (clk),
    .reset      (reset),
    .arb_en     (arb_en),
    .i_req      (i_req),
    .d_req      (d_req),
    .grant_fire (grant_fire),
    .sel_i      (sel_i),
    .sel_d      (sel_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    i_gnt   = sel_i;
    d_gnt   = sel_d;
    mem_req = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_fire) state_d = ACCESS;
      end
      ACCESS: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction fields are frozen at grant so the memory sees a stable request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_I;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant_fire) begin
      owner_q   <= sel_d ? OWN_D : OWN_I;
      mem_we    <= sel_d && d_we;
      mem_addr  <= sel_d ? d_addr : i_addr;
      mem_wdata <= sel_d ? d_wdata : '0;
      mem_be    <= sel_d ? d_be : '1;
    end
  end

  // A flush during a fetch, including its ack cycle, makes the response stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kill_q <= 1'b0;
    end else if (ack_fire) begin
      kill_q <= 1'b0;
    end else if ((state_q == ACCESS) && (owner_q == OWN_I) && i_flush) begin
      kill_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= i_deliver;
      d_rvalid <= ack_fire && (owner_q == OWN_D);
      if (i_deliver) i_rdata <= mem_rdata;
      if (ack_fire && (owner_q == OWN_D) && !mem_we) d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench: grants push expected responses, a monitor pops on rvalid.
module tb_imem_dmem_arbiter;

  localparam int DATA_W   = 32;
  localparam int MAX_DWIN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req, i_flush, i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_addr, i_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0]        d_be, mem_be;
  logic              mem_req, mem_we, mem_ack, busy;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t i_q[$];
  exp_t d_q[$];
  exp_t e_i, e_d;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_k = 1;
  int rcnt = 0;
  logic [31:0] mem_tbl [logic [31:0]];
  string seq;
  int g1, g2, gd, gi, ng;

  imem_dmem_arbiter #(.DATA_W(DATA_W), .MAX_DWIN(MAX_DWIN)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks ack_k cycles into the request, data from mem_tbl.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !mem_ack) begin
        rcnt++;
        if (rcnt >= ack_k) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_tbl.exists(mem_addr) ? mem_tbl[mem_addr] : 32'hBAD0_0000;
        end
      end else begin
        mem_ack = 1'b0;
        rcnt    = 0;
      end
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (i_rvalid) begin
      checks++;
      if (i_q.size() == 0) begin
        errors++;
        $display("FAIL i_rsp_unexpected: got i_rvalid data %h at cycle %0d, required none", i_rdata, cyc);
      end else begin
        e_i = i_q.pop_front();
        if (i_rdata !== e_i.data || cyc != e_i.cyc) begin
          errors++;
          $display("FAIL i_rsp: got %h at cycle %0d, required %h at cycle %0d", i_rdata, cyc, e_i.data, e_i.cyc);
        end
      end
    end
    if (d_rvalid) begin
      checks++;
      if (d_q.size() == 0) begin
        errors++;
        $display("FAIL d_rsp_unexpected: got d_rvalid data %h at cycle %0d, required none", d_rdata, cyc);
      end else begin
        e_d = d_q.pop_front();
        if (d_rdata !== e_d.data || cyc != e_d.cyc) begin
          errors++;
          $display("FAIL d_rsp: got %h at cycle %0d, required %h at cycle %0d", d_rdata, cyc, e_d.data, e_d.cyc);
        end
      end
    end
  end

  // Call just after a rising edge; drives the request and holds it until granted.
  task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input bit exp_rsp, input logic [31:0] exp_data, output int gcyc);
    bit found = 0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (is_d ? d_gnt : i_gnt) found = 1;
    end
    gcyc = cyc;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL grant_timeout: got no grant for addr %h, required a grant", addr);
    end else if (exp_rsp) begin
      if (is_d) d_q.push_back('{data: exp_data, cyc: cyc + ack_k + 1});
      else      i_q.push_back('{data: exp_data, cyc: cyc + ack_k + 1});
    end
    @(posedge clk); #1;
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
    @(negedge clk);
    chk("mem_req_after_gnt", mem_req, 1'b1);
    chk("mem_addr", mem_addr, addr);
    chk("mem_we", mem_we, is_d ? we : 1'b0);
    chk("mem_be", mem_be, is_d ? be : 4'hF);
    if (is_d) chk("mem_wdata", mem_wdata, wdata);
  endtask

  initial begin
    reset = 1'b0; i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_tbl[32'h40] = 32'h0051_3093;
    mem_tbl[32'h44] = 32'h00A0_0113;
    mem_tbl[32'h48] = 32'h00B0_0193;
    mem_tbl[32'h4C] = 32'hFFFF_0000;
    mem_tbl[32'h50] = 32'h00C0_0213;
    mem_tbl[32'h58] = 32'h00D0_0293;
    mem_tbl[32'h100] = 32'h1111_0100;
    mem_tbl[32'h300] = 32'h3333_0300;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, busy, mem_we}, 7'b0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_be", mem_be, 4'h0);
    chk("reset_i_rdata", i_rdata, 32'h0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single fetch, ack two cycles into the access
    ack_k = 2;
    @(posedge clk); #1;
    issue(0, 0, 32'h40, 32'h0, 4'h0, 1, 32'h0051_3093, g1);
    repeat (5) @(posedge clk); #1;

    // Simultaneous fetch and load: data first
    ack_k = 1;
    fork
      issue(1, 0, 32'h100, 32'h0, 4'hF, 1, 32'h1111_0100, gd);
      issue(0, 0, 32'h44, 32'h0, 4'h0, 1, 32'h00A0_0113, gi);
    join
    chk("i_gnt_after_d", gi, gd + 2);
    repeat (5) @(posedge clk); #1;

    // Store: fields held through the access, d_rdata keeps the last load
    ack_k = 3;
    issue(1, 1, 32'h200, 32'hDEAD_BEEF, 4'h3, 1, 32'h1111_0100, g1);
    @(negedge clk);
    chk("store_hold_req", mem_req, 1'b1);
    chk("store_hold_we", mem_we, 1'b1);
    chk("store_hold_be", mem_be, 4'h3);
    repeat (5) @(posedge clk); #1;

    // Starvation limit with both requesters held
    ack_k = 1;
    seq = "";
    ng = 0;
    d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
    i_req = 1; i_addr = 32'h48;
    for (int n = 0; n < 60 && ng < 6; n++) begin
      @(negedge clk);
      if (d_gnt) begin
        seq = {seq, "D"}; ng++;
        d_q.push_back('{data: 32'h3333_0300, cyc: cyc + 2});
      end
      if (i_gnt) begin
        seq = {seq, "I"}; ng++;
        i_q.push_back('{data: 32'h00B0_0193, cyc: cyc + 2});
      end
    end
    @(posedge clk); #1;
    d_req = 0; i_req = 0;
    checks++;
    if (seq != "DDDDID") begin
      errors++;
      $display("FAIL starvation_seq: got %s required DDDDID", seq);
    end
    repeat (5) @(posedge clk); #1;

    // Flush kills an in-flight fetch; next fetch granted right after the ack
    ack_k = 3;
    issue(0, 0, 32'h4C, 32'h0, 4'h0, 0, 32'h0, g1);
    @(posedge clk); #1;
    i_flush = 1;
    @(posedge clk); #1;
    i_flush = 0;
    issue(0, 0, 32'h50, 32'h0, 4'h0, 1, 32'h00C0_0213, g2);
    chk("flush_regrant_cyc", g2, g1 + 4);
    chk("flush_rdata_kept", i_rdata, 32'h00B0_0193);
    repeat (6) @(posedge clk); #1;

    // Reset during an access abandons it
    ack_k = 20;
    issue(0, 0, 32'h54, 32'h0, 4'h0, 0, 32'h0, g1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mem_req_drop", mem_req, 1'b0);
    chk("rst_busy_drop", busy, 1'b0);
    @(posedge clk); #1;
    chk("rst_i_rdata", i_rdata, 32'h0);
    reset = 1'b1;
    ack_k = 1;
    @(posedge clk); #1;
    issue(0, 0, 32'h58, 32'h0, 4'h0, 1, 32'h00D0_0293, g1);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("i_q_drained", i_q.size(), 0);
    chk("d_q_drained", d_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
